// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: instruction layout and FSM states.
package alu_seq_pkg;

  localparam int unsigned INSTR_W = 20;

  // Instruction word fields: {ALU_Sel, A, B}
  localparam int unsigned SEL_HI = 19;
  localparam int unsigned SEL_LO = 16;
  localparam int unsigned A_HI   = 15;
  localparam int unsigned A_LO   = 8;
  localparam int unsigned B_HI   = 7;
  localparam int unsigned B_LO   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x INSTR_W registers, one synchronous write port, one async read port.
module alu_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Array is intentionally unreset; the owner's count gates which entries are live.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Replays a host-loaded program of ALU instructions, one per cycle, then captures Acc.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ALU_LAT  = 1,
  parameter logic [3:0]  IDLE_SEL = 4'b0000,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1,
  localparam int unsigned DW = $clog2(ALU_LAT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_valid_i,
  input  logic [INSTR_W-1:0] load_data_i,
  output logic               load_ready_o,
  input  logic               clr_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CW-1:0]      count_o,
  output logic [7:0]         a_o,
  output logic [7:0]         b_o,
  output logic [3:0]         alu_sel_o,
  input  logic [7:0]         acc_i,
  output logic [7:0]         result_o
);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [7:0]         result_q, result_d;

  logic               load_hs;
  logic               last_word;
  logic [CW-1:0]      eff_count;
  logic [INSTR_W-1:0] instr;

  assign load_ready_o = (state_q == StIdle) && (count_q < CW'(DEPTH));
  assign load_hs      = load_valid_i && load_ready_o;
  // A word loaded in the start cycle joins the run.
  assign eff_count    = count_q + CW'(load_hs);
  assign last_word    = ({1'b0, pc_q} == (count_q - CW'(1)));

  alu_prog_mem #(
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk_i   (clk_i),
    .we_i    (load_hs && !clr_i),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (load_data_i),
    .raddr_i (pc_q),
    .rdata_o (instr)
  );

  // Next-state logic: loading/clear/start in idle, sequencing through issue and drain.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pc_d     = pc_q;
    drain_d  = drain_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          count_d = '0;
        end else begin
          if (load_hs) begin
            count_d = count_q + CW'(1);
          end
          if (start_i) begin
            pc_d    = '0;
            drain_d = '0;
            state_d = (eff_count == '0) ? StDone : StIssue;
          end
        end
      end
      StIssue: begin
        if (last_word) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DW'(ALU_LAT - 1)) begin
          state_d  = StDone;
          result_d = acc_i;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      count_q  <= '0;
      pc_q     <= '0;
      drain_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      drain_q  <= drain_d;
      result_q <= result_d;
    end
  end

  // ALU drive: fields of the current word while issuing, idle pattern otherwise.
  always_comb begin
    a_o       = 8'h00;
    b_o       = 8'h00;
    alu_sel_o = IDLE_SEL;
    if (state_q == StIssue) begin
      a_o       = instr[A_HI:A_LO];
      b_o       = instr[B_HI:B_LO];
      alu_sel_o = instr[SEL_HI:SEL_LO];
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign count_o  = count_q;
  assign result_o = result_q;

endmodule
